// File: rtl/trivium_seq_ctrl_if.sv
// ============================================================================
// Module      : trivium_seq_ctrl_if
// Description : Core-control and keystream valid/ready bundle used between
//               the Trivium sequencer, the bit-serial core and the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trivium_seq_ctrl_if #(
  parameter int OUT_W = 8
);
  logic             core_load;
  logic             core_step;
  logic             core_ks;
  logic [OUT_W-1:0] ks_data;
  logic             ks_valid;
  logic             ks_ready;

  // Sequencer side: drives the core strobes and the keystream word.
  modport master (
    output core_load,
    output core_step,
    output ks_data,
    output ks_valid,
    input  core_ks,
    input  ks_ready
  );

  // Core/consumer side: supplies keystream bits and accepts words.
  modport slave (
    input  core_load,
    input  core_step,
    input  ks_data,
    input  ks_valid,
    output core_ks,
    output ks_ready
  );
endinterface

`default_nettype wire

// File: rtl/trivium_seq_ctrl.sv
// ============================================================================
// Module      : trivium_seq_ctrl
// Description : Sequencer for a bit-serial Trivium-style keystream core.
//               Issues a one-cycle key/IV load, a fixed warm-up of discarded
//               steps, then steps the core continuously and packs keystream
//               bits into OUT_W-bit words on a valid/ready interface.
//               Optional word-limit feature: define TRIV_KS_LIMIT_EN to add
//               the ks_limit input and the done output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trivium_seq_ctrl #(
  parameter int WARMUP = 1152,
  parameter int CNT_W  = 11,
  parameter int OUT_W  = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic        stop,
`ifdef TRIV_KS_LIMIT_EN
  input  wire logic [15:0] ks_limit,
  output logic             done,
`endif
  output logic             busy,
  output logic             warm_done,
  trivium_seq_ctrl_if.master ks_if
);

  localparam int               BC_W      = (OUT_W > 2) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(OUT_W - 1);
  localparam logic [BC_W-1:0]  BIT_ONE   = BC_W'(1);
`ifdef TRIV_KS_LIMIT_EN
  localparam logic [15:0]      WORD_ONE  = 16'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WARM = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [BC_W-1:0]  bitcnt_q,   bitcnt_d;
  logic [OUT_W-1:0] sreg_q,     sreg_d;
  logic [OUT_W-1:0] ks_data_q,  ks_data_d;
  logic             ks_valid_q, ks_valid_d;
`ifdef TRIV_KS_LIMIT_EN
  logic [15:0]      limit_q,    limit_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             done_q,     done_d;
  logic             w_limit_hit;
`endif

  logic             w_last;
  logic             w_accept;
  logic             w_step_en;
  logic             w_core_step;
  logic             w_abort;
  logic [OUT_W-1:0] w_word;

  // Handshake and stall decode: the word-completing step is held back while
  // the output register is full and not being drained this cycle.
  always_comb begin
    w_last    = (bitcnt_q == LAST_BIT);
    w_accept  = ks_valid_q & ks_if.ks_ready;
    w_step_en = !(w_last & ks_valid_q & !ks_if.ks_ready);
  end

  // Completed word: collected bits plus the bit arriving on this step.
  always_comb begin
    w_word            = sreg_q;
    w_word[OUT_W-1]   = ks_if.core_ks;
  end

  // Next-state, counters, packing and output-register update.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    bitcnt_d    = bitcnt_q;
    sreg_d      = sreg_q;
    ks_data_d   = ks_data_q;
    ks_valid_d  = ks_valid_q;
    w_core_step = 1'b0;
    w_abort     = 1'b0;
`ifdef TRIV_KS_LIMIT_EN
    limit_d     = limit_q;
    word_cnt_d  = word_cnt_q;
    done_d      = 1'b0;
    w_limit_hit = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        warm_cnt_d = '0;
        state_d    = S_WARM;
`ifdef TRIV_KS_LIMIT_EN
        limit_d    = ks_limit;
        word_cnt_d = '0;
`endif
      end
      S_WARM: begin
        // Warm-up bits from the core are discarded.
        w_core_step = 1'b1;
        if (warm_cnt_q == WARM_LAST) begin
          state_d    = S_RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        w_core_step = w_step_en;
        if (w_accept) begin
          ks_valid_d = 1'b0;
        end
        if (w_step_en) begin
          if (w_last) begin
            // A completing word overrides the consume-clear above.
            ks_data_d  = w_word;
            ks_valid_d = 1'b1;
            bitcnt_d   = '0;
            sreg_d     = '0;
          end else begin
            sreg_d[bitcnt_q] = ks_if.core_ks;
            bitcnt_d         = bitcnt_q + BIT_ONE;
          end
        end
`ifdef TRIV_KS_LIMIT_EN
        if (w_accept) begin
          word_cnt_d = word_cnt_q + WORD_ONE;
          if ((limit_q != 16'd0) && (word_cnt_d == limit_q)) begin
            w_limit_hit = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      w_abort = 1'b1;
    end
`ifdef TRIV_KS_LIMIT_EN
    // stop wins over a limit hit in the same cycle, so no done pulse then.
    if (w_limit_hit && !w_abort) begin
      w_abort = 1'b1;
      done_d  = 1'b1;
    end
`endif

    // Any exit to IDLE discards the partial word and the pending output.
    if (w_abort) begin
      state_d    = S_IDLE;
      warm_cnt_d = '0;
      bitcnt_d   = '0;
      sreg_d     = '0;
      ks_data_d  = '0;
      ks_valid_d = 1'b0;
`ifdef TRIV_KS_LIMIT_EN
      word_cnt_d = '0;
`endif
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      warm_cnt_q <= '0;
      bitcnt_q   <= '0;
      sreg_q     <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
`ifdef TRIV_KS_LIMIT_EN
      limit_q    <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      bitcnt_q   <= bitcnt_d;
      sreg_q     <= sreg_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
`ifdef TRIV_KS_LIMIT_EN
      limit_q    <= limit_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
`endif
    end
  end

  assign ks_if.core_load = (state_q == S_LOAD);
  assign ks_if.core_step = w_core_step;
  assign ks_if.ks_data   = ks_data_q;
  assign ks_if.ks_valid  = ks_valid_q;
  assign busy            = (state_q != S_IDLE);
  assign warm_done       = (state_q == S_RUN);
`ifdef TRIV_KS_LIMIT_EN
  assign done            = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trivium_seq_ctrl.sv
// ============================================================================
// Module      : tb_trivium_seq_ctrl
// Description : Self-checking bench for trivium_seq_ctrl. A behavioural core
//               feeds bits from a reference stream; expected words are queued
//               as the core emits each word's last bit and compared when the
//               DUT hands a word over.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trivium_seq_ctrl;

  localparam int WARMUP = 4;
  localparam int CNT_W  = 3;
  localparam int OUT_W  = 8;
  localparam int REF_N  = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic busy;
  logic warm_done;
`ifdef TRIV_KS_LIMIT_EN
  logic [15:0] ks_limit = 16'd0;
  logic        done;
`endif

  trivium_seq_ctrl_if #(.OUT_W(OUT_W)) ks_if ();

  trivium_seq_ctrl #(
    .WARMUP (WARMUP),
    .CNT_W  (CNT_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
`ifdef TRIV_KS_LIMIT_EN
    .ks_limit  (ks_limit),
    .done      (done),
`endif
    .busy      (busy),
    .warm_done (warm_done),
    .ks_if     (ks_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_words  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural core + expectation generator ----------------
  logic             ref_bits [0:REF_N-1];
  int unsigned      core_idx = 0;
  logic             garb     = 1'b0;
  logic [OUT_W-1:0] exp_q [$];

  function automatic logic [OUT_W-1:0] ref_word(input int unsigned base);
    logic [OUT_W-1:0] w;
    for (int j = 0; j < OUT_W; j++) w[j] = ref_bits[(base + j) % REF_N];
    return w;
  endfunction

  always @(posedge clk) begin
    garb <= 1'($urandom);
    if (ks_if.core_load) begin
      core_idx <= 0;
    end else if (ks_if.core_step) begin
      core_idx <= core_idx + 1;
      if (core_idx >= WARMUP && ((core_idx - WARMUP) % OUT_W) == OUT_W - 1)
        exp_q.push_back(ref_word(core_idx - WARMUP - (OUT_W - 1)));
    end
  end

  assign ks_if.core_ks = (core_idx >= WARMUP) ? ref_bits[(core_idx - WARMUP) % REF_N] : garb;

  // ---------------- output monitor: scoreboard + hold rule ------------------
  logic             hold_pend = 1'b0;
  logic [OUT_W-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(ks_if.ks_valid), 32'd1);
        check("hold_data", 32'(ks_if.ks_data), 32'(hold_data));
      end
      hold_pend <= ks_if.ks_valid && !ks_if.ks_ready && !stop;
      hold_data <= ks_if.ks_data;
      if (ks_if.ks_valid && ks_if.ks_ready) begin
        check("sb_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("sb_word", 32'(ks_if.ks_data), 32'(exp_q.pop_front()));
          n_words <= n_words + 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start at the next edge and verify load, warm-up length and RUN entry.
  // Returns in cycle 6 (first RUN step).
  task automatic run_head();
    int steps;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_cycle1", 32'(ks_if.core_load), 32'd1);
    check("step_cycle1", 32'(ks_if.core_step), 32'd0);
    check("busy_cycle1", 32'(busy), 32'd1);
    steps = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      steps += int'(ks_if.core_step);
      if (c == 5) check("warm_done_in_warm", 32'(warm_done), 32'd0);
    end
    check("warm_steps", 32'(steps), 32'(WARMUP));
    tick();
    check("warm_done_run", 32'(warm_done), 32'd1);
    check("step_run", 32'(ks_if.core_step), 32'd1);
    check("load_run", 32'(ks_if.core_load), 32'd0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_valid", 32'(ks_if.ks_valid), 32'd0);
    check("stop_data", 32'(ks_if.ks_data), 32'd0);
    check("stop_step", 32'(ks_if.core_step), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence --------------------------------------------
  initial begin
    logic [OUT_W-1:0] w1;
    logic [OUT_W-1:0] w2;
    int stall_steps;
    int base_words;
    int waited;
    int active;
`ifdef TRIV_KS_LIMIT_EN
    int done_cnt;
`endif
    w1 = 8'h4D;
    w2 = 8'hA5;
    for (int i = 0; i < REF_N; i++) ref_bits[i] = 1'($urandom);
    for (int j = 0; j < OUT_W; j++) begin
      ref_bits[j]         = w1[j];
      ref_bits[OUT_W + j] = w2[j];
    end
    ks_if.ks_ready = 1'b0;

    // Reset state
    tick();
    check("rst_load", 32'(ks_if.core_load), 32'd0);
    check("rst_step", 32'(ks_if.core_step), 32'd0);
    check("rst_valid", 32'(ks_if.ks_valid), 32'd0);
    check("rst_data", 32'(ks_if.ks_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_warm_done", 32'(warm_done), 32'd0);
    reset = 1'b1;
    ticks(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic sequence: first word 0x4D in cycle 14 for one cycle
    ks_if.ks_ready = 1'b1;
    run_head();
    ticks(7);
    check("basic_valid_c13", 32'(ks_if.ks_valid), 32'd0);
    tick();
    check("basic_valid_c14", 32'(ks_if.ks_valid), 32'd1);
    check("basic_data_c14", 32'(ks_if.ks_data), 32'h4D);
    tick();
    check("basic_valid_c15", 32'(ks_if.ks_valid), 32'd0);
    for (int i = 0; i < 60; i++) begin
      ks_if.ks_ready = 1'($urandom);
      tick();
    end
    do_stop();

    // Backpressure: ready low in cycles 14..33, released in cycle 34
    ks_if.ks_ready = 1'b0;
    run_head();
    ticks(8);
    check("bp_valid_c14", 32'(ks_if.ks_valid), 32'd1);
    check("bp_data_c14", 32'(ks_if.ks_data), 32'h4D);
    stall_steps = 0;
    for (int c = 15; c <= 34; c++) begin
      tick();
      if (c == 20) check("bp_step_c20", 32'(ks_if.core_step), 32'd1);
      if (c >= 21) stall_steps += int'(ks_if.core_step);
    end
    check("bp_stall_steps", 32'(stall_steps), 32'd0);
    check("bp_held_data", 32'(ks_if.ks_data), 32'h4D);
    ks_if.ks_ready = 1'b1;
    #1;
    check("bp_release_step", 32'(ks_if.core_step), 32'd1);
    tick();
    check("bp_valid_c35", 32'(ks_if.ks_valid), 32'd1);
    check("bp_data_c35", 32'(ks_if.ks_data), 32'hA5);
    for (int i = 0; i < 80; i++) begin
      ks_if.ks_ready = 1'($urandom);
      tick();
    end
    ks_if.ks_ready = 1'b0;
    waited = 0;
    while (!ks_if.ks_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("bp_valid_before_stop", 32'(ks_if.ks_valid), 32'd1);
    do_stop();

    // Abort at the 5th RUN step, then a clean restart
    ks_if.ks_ready = 1'b1;
    run_head();
    ticks(4);
    check("abort_c10_run", 32'(warm_done), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(ks_if.ks_valid), 32'd0);
    check("abort_data", 32'(ks_if.ks_data), 32'd0);
    check("abort_step", 32'(ks_if.core_step), 32'd0);
    check("abort_warm_done", 32'(warm_done), 32'd0);
    exp_q.delete();
    tick();
    check("abort_step_later", 32'(ks_if.core_step), 32'd0);
    run_head();
    ticks(8);
    check("restart_valid_c14", 32'(ks_if.ks_valid), 32'd1);
    check("restart_data_c14", 32'(ks_if.ks_data), 32'h4D);
    do_stop();

    // start & stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_load", 32'(ks_if.core_load), 32'd0);
    tick();
    check("prio_busy_later", 32'(busy), 32'd0);

    // start during RUN is ignored; stream continues
    ks_if.ks_ready = 1'b1;
    run_head();
    ticks(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rerun_load", 32'(ks_if.core_load), 32'd0);
    check("rerun_warm_done", 32'(warm_done), 32'd1);
    base_words = n_words;
    ticks(40);
    check("rerun_words", 32'(n_words - base_words), 32'd5);
    do_stop();

    // Asynchronous reset mid-WARM
    run_head();
    do_stop();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_load", 32'(ks_if.core_load), 32'd0);
    check("arst_step", 32'(ks_if.core_step), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(ks_if.ks_valid), 32'd0);
    check("arst_data", 32'(ks_if.ks_data), 32'd0);
    check("arst_warm_done", 32'(warm_done), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    active = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      active += int'(busy) + int'(ks_if.core_step) + int'(ks_if.core_load);
    end
    check("arst_stays_idle", 32'(active), 32'd0);

`ifdef TRIV_KS_LIMIT_EN
    // Word limit of 3
    ks_limit       = 16'd3;
    ks_if.ks_ready = 1'b1;
    base_words     = n_words;
    done_cnt       = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check("limit_words", 32'(n_words - base_words), 32'd3);
    check("limit_done_pulses", 32'(done_cnt), 32'd1);
    check("limit_busy_after", 32'(busy), 32'd0);
    exp_q.delete();

    // Unlimited
    ks_limit   = 16'd0;
    base_words = n_words;
    done_cnt   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check("unlim_many_words", 32'((n_words - base_words) > 10), 32'd1);
    check("unlim_no_done", 32'(done_cnt), 32'd0);
    do_stop();
`endif

    ticks(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/trivium_seq_ctrl.md
Name: trivium_seq_ctrl

Overview:
- Sequencer for the bit-serial Trivium-style keystream core (shift register and feedback taps, one keystream bit per step).
- Issues a one-cycle key/IV load, then a fixed warm-up of discarded steps.
- Then steps the core continuously, packing keystream bits into OUT_W-bit words delivered over a valid/ready interface with backpressure.
- Sits between the core and the encrypt/XOR datapath.

Parameters:
- WARMUP, 1152: number of discarded warm-up steps after load; must be >= 1.
- CNT_W, 11: width of the warm-up counter; must satisfy 2^CNT_W > WARMUP.
- OUT_W, 8: keystream word width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state)
- start  input  1  request a new load + warm-up + run sequence
- stop  input  1  abort the current sequence, return to IDLE
- core_load  output  1  one-cycle strobe: core latches key/IV
- core_step  output  1  core advances one round this cycle
- core_ks  input  1  core keystream bit for the current state; valid whenever core_step=1
- ks_data  output  OUT_W  packed keystream word; bit 0 is the earliest bit
- ks_valid  output  1  ks_data holds an unconsumed word
- ks_ready  input  1  consumer accepts the word when ks_valid & ks_ready
- busy  output  1  state != IDLE
- warm_done  output  1  high while in RUN

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; warm-up counter and bit counter = 0; shift register = 0.
  - Outputs during reset: ks_data=0, ks_valid=0, core_load=0, core_step=0, busy=0, warm_done=0.
- All outputs are registered or decoded from state only, except core_step in RUN (see stall rule).
- FSM IDLE:
  - start=1 & stop=0 -> LOAD.
  - stop has priority over start.
- FSM LOAD:
  - core_load=1 for exactly one cycle -> WARM.
  - Warm-up counter is cleared.
- FSM WARM:
  - core_step=1 every cycle; core_ks is ignored; counter increments.
  - At counter==WARMUP-1 -> RUN.
  - Exactly WARMUP steps are issued.
- FSM RUN:
  - core_step=step_en; each step shifts core_ks into bit position bitcnt.
  - bitcnt wraps OUT_W-1 -> 0.
- Stall rule: step_en = !(bitcnt==OUT_W-1 & ks_valid & !ks_ready).
  - The word-completing step is withheld while the output register is full and not being drained.
  - The core never advances with an unconsumed word pending plus a full shift register.
- Word completion:
  - On a step with bitcnt==OUT_W-1, the complete word (including the current core_ks) moves to ks_data and ks_valid=1 next cycle.
  - If ks_valid & ks_ready in the same cycle, the old word is consumed and the new one is loaded.
  - No bubble; sustained throughput is one word per OUT_W cycles.
- Handshake:
  - ks_valid, once set, stays high with ks_data stable until ks_ready=1.
  - ks_valid & ks_ready with no new word completing -> ks_valid=0.
- Latency:
  - start sampled at edge N -> core_load high in cycle N+1.
  - WARM occupies cycles N+2 .. N+1+WARMUP.
  - First RUN step is in cycle N+2+WARMUP.
  - First ks_valid is in cycle N+2+WARMUP+OUT_W, assuming no stalls.
- start while busy: ignored (no restart).
- stop in LOAD/WARM/RUN -> IDLE next edge.
  - Clears the counters, the shift register, ks_valid and ks_data.
  - core_step=0 from that cycle on.
  - A partial word is discarded.
- Asynchronous reset mid-sequence: same effect as stop, but immediate. A new start is required afterwards, and the core must be reloaded.
- warm_done=1 only in RUN; busy=1 in LOAD, WARM and RUN.

Optional Feature:
- Macro: TRIV_KS_LIMIT_EN.
- Defined:
  - Adds input ks_limit[15:0], sampled in LOAD.
  - Adds output done (1 bit, reset 0).
  - A word counter counts words accepted (ks_valid & ks_ready).
  - When the count reaches ks_limit, the controller stops stepping, returns to IDLE, and pulses done for 1 cycle.
  - ks_limit=0 means unlimited.
  - stop or reset suppresses done.
- Not defined: neither port exists; RUN continues until stop or reset.

Test Plan:
- Reset, then idle: reset=0 mid-WARM (WARMUP=4, OUT_W=8) -> all outputs 0 immediately; after release, stay IDLE with busy=0 until start.
- Basic sequence: WARMUP=4, OUT_W=8, ks_ready=1, start at edge 0, core_ks bits 1,0,1,1,0,0,1,0 in the first RUN steps:
  - core_load in cycle 1.
  - core_step in cycles 2-5 with core_ks ignored.
  - ks_valid=1 with ks_data=8'h4D in cycle 14 for exactly one cycle.
- Backpressure: hold ks_ready=0 for 20 cycles after the first word -> ks_data stays 8'h4D; the second word's last step is withheld (core_step=0) from its completion point; ks_ready=1 -> second word appears the next cycle; no keystream bit is lost or duplicated (compare against a reference bit stream).
- Abort: stop asserted at the 5th RUN step -> IDLE next edge; ks_valid=0, ks_data=0, core_step=0; a subsequent start re-issues core_load and the full WARMUP steps.
- Start/stop priority: start & stop together in IDLE -> stay IDLE; start during RUN -> no core_load, word stream uninterrupted.
- TRIV_KS_LIMIT_EN: ks_limit=3, ks_ready=1 -> exactly 3 words accepted, done pulses 1 cycle, busy=0 after; ks_limit=0 -> more than 10 words with no done.
